rf_wb_arbiter: RTL

//  Writer side of the 16x16 register-file write port (we/dst_addr/dst). Merges single-cycle ALU

---
 rtl/rf_wb_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges single-cycle ALU results and buffered load results into one registered
// register-file write per clock. Define WB_FWD_EN to add the chk_hit/chk_data forwarding outputs.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_vld,
  input  logic [3:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        mem_vld,
  output logic        mem_rdy,
  input  logic [3:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        we,
  output logic [3:0]  dst_addr,
  output logic [15:0] dst,
  output logic        alu_stall,
  input  logic [3:0]  chk_addr,
  output logic        chk_pend
`ifdef WB_FWD_EN
  ,
  output logic        chk_hit,
  output logic [15:0] chk_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  // Load handshake: a load transfers on a posedge where mem_vld && mem_rdy; mem_rdy depends only
  // on FIFO occupancy. The ALU side has no ready and must be consumed in the cycle it is valid.
  logic [3:0]       fifo_addr_q [DEPTH];
  logic [15:0]      fifo_data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             we_q, we_d;
  logic [3:0]       dst_addr_q, dst_addr_d;
  logic [15:0]      dst_q, dst_d;

  logic          empty, full, pop, bypass, squash_in, push, pend_fifo;
  logic [PW-1:0] head, tail;

  assign head      = rd_ptr_q[PW-1:0];
  assign tail      = wr_ptr_q[PW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (head == tail);
  assign mem_rdy   = !full;
  assign pop       = !alu_vld && !empty;
  assign bypass    = !alu_vld && empty && mem_vld;
  // A load to the register the ALU is writing this cycle is older than the ALU result: drop it.
  assign squash_in = alu_vld && (mem_addr == alu_addr);
  assign push      = mem_vld && mem_rdy && !bypass && !squash_in;
  assign wr_ptr_d  = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{PW{1'b0}}, pop};

  always_comb begin
    live_d = live_q;
    if (alu_vld) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_addr_q[i] == alu_addr) live_d[i] = 1'b0;
      end
    end
    if (pop)  live_d[head] = 1'b0;
    if (push) live_d[tail] = 1'b1;
  end

  // Writes to r0 still consume their slot but never raise we.
  always_comb begin
    we_d       = 1'b0;
    dst_addr_d = dst_addr_q;
    dst_d      = dst_q;
    if (alu_vld) begin
      we_d       = (alu_addr != 4'd0);
      dst_addr_d = alu_addr;
      dst_d      = alu_data;
    end else if (!empty) begin
      we_d       = live_q[head] && (fifo_addr_q[head] != 4'd0);
      dst_addr_d = fifo_addr_q[head];
      dst_d      = fifo_data_q[head];
    end else if (mem_vld) begin
      we_d       = (mem_addr != 4'd0);
      dst_addr_d = mem_addr;
      dst_d      = mem_data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop) starve_d = '0;
    else if (full && alu_vld && (starve_q != CW'(STARVE_MAX))) starve_d = starve_q + 1'b1;
    stall_d = stall_q;
    if (starve_q == CW'(STARVE_MAX)) stall_d = 1'b1;
    if (wr_ptr_d == rd_ptr_d)        stall_d = 1'b0;
  end

  always_comb begin
    pend_fifo = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (fifo_addr_q[i] == chk_addr)) pend_fifo = 1'b1;
    end
  end
  assign chk_pend = (chk_addr != 4'd0) && ((mem_vld && (mem_addr == chk_addr)) || pend_fifo);

`ifdef WB_FWD_EN
  logic [15:0]   fwd_data;
  logic [PW-1:0] fwd_idx;
  // Walk oldest to newest so the newest live FIFO match wins, then the inputs override it.
  always_comb begin
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if (live_q[fwd_idx] && (fifo_addr_q[fwd_idx] == chk_addr)) fwd_data = fifo_data_q[fwd_idx];
    end
    if (mem_vld && (mem_addr == chk_addr)) fwd_data = mem_data;
    if (alu_vld && (alu_addr == chk_addr)) fwd_data = alu_data;
    if (chk_addr == 4'd0) fwd_data = '0;
  end
  assign chk_hit  = chk_pend;
  assign chk_data = fwd_data;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail] <= mem_addr;
      fifo_data_q[tail] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      live_q     <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      we_q       <= 1'b0;
      dst_addr_q <= '0;
      dst_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      live_q     <= live_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      we_q       <= we_d;
      dst_addr_q <= dst_addr_d;
      dst_q      <= dst_d;
    end
  end

  assign we        = we_q;
  assign dst_addr  = dst_addr_q;
  assign dst       = dst_q;
  assign alu_stall = stall_q;

endmodule
